// File: rtl/lc3_mem_ctrl.sv
// Memory-side responder for the LC3 core: arbitrates instruction and data requests onto one
// single-ported synchronous RAM with programmable wait states and one-cycle completion pulses.
module lc3_mem_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned DATA_PRIO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  input  logic        i_macc,
  output logic [15:0] instr_dout,
  output logic        complete_instr,
  input  logic [15:0] data_addr,
  input  logic [15:0] data_din,
  input  logic        data_rd,
  input  logic        d_macc,
  output logic [15:0] data_dout,
  output logic        complete_data,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StWait, StIssue, StResp, StDone} state_e;

  localparam logic [3:0] WaitCnt   = 4'(WAIT_STATES);
  localparam bit         DataFirst = (DATA_PRIO != 0);
  localparam bit         HasWait   = (WAIT_STATES != 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        chan_q, chan_d;  // 1 = data channel owns the transaction
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] idout_q, idout_d;
  logic [15:0] ddout_q, ddout_d;

  logic i_req, d_req, take_data;

  assign i_req     = i_macc & instrmem_rd;
  assign d_req     = d_macc;
  assign take_data = d_req & (DataFirst | ~i_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      chan_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idout_q <= '0;
      ddout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idout_q <= idout_d;
      ddout_q <= ddout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_req | d_req) state_d = HasWait ? StWait : StIssue;
      StWait:  if (cnt_q <= 4'd1) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latching, wait counting and read-data capture.
  always_comb begin
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idout_d = idout_q;
    ddout_d = ddout_q;
    unique case (state_q)
      StIdle: begin
        if (i_req | d_req) begin
          chan_d = take_data;
          wr_d   = take_data & ~data_rd;
          addr_d = take_data ? data_addr : pc;
          cnt_d  = WaitCnt;
          if (take_data) wdata_d = data_din;
        end
      end
      StWait: cnt_d = cnt_q - 4'd1;
      StResp: begin
        if (!chan_q) idout_d = mem_rdata;
        else if (!wr_q) ddout_d = mem_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    mem_en         = (state_q == StIssue) & ~rst;
    mem_we         = mem_en & wr_q;
    complete_instr = (state_q == StDone) & ~chan_q;
    complete_data  = (state_q == StDone) & chan_q;
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign instr_dout = idout_q;
  assign data_dout  = ddout_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: four configurations share stimulus; the active one is checked every
// cycle against a transaction-timeline model, plus directed literal expectations.
module tb_lc3_mem_ctrl;

  // Configurations: 0:(WS0,prio data) 1:(WS2,prio data) 2:(WS3,prio data) 3:(WS0,prio instr)
  localparam logic [3:0][3:0] WS_T = {4'd0, 4'd3, 4'd2, 4'd0};
  localparam logic [3:0]      DP_T = 4'b0111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = '0, data_addr = '0, data_din = '0;
  logic        instrmem_rd = 1'b0, i_macc = 1'b0, data_rd = 1'b0, d_macc = 1'b0;
  logic [15:0] mem_rdata;

  logic [3:0]        busy_a, en_a, we_a, ci_a, cd_a;
  logic [3:0][15:0]  addr_a, wdata_a, idout_a, ddout_a;

  int active = 0;
  int n_vec  = 0;
  int n_err  = 0;

  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0, poke_val = '0;
  logic [15:0] ram [65536];
  logic        ci_seen = 1'b0, cd_seen = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    lc3_mem_ctrl #(
      .WAIT_STATES(32'(WS_T[g])),
      .DATA_PRIO  (32'(DP_T[g]))
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .pc            (pc),
      .instrmem_rd   (instrmem_rd),
      .i_macc        (i_macc),
      .instr_dout    (idout_a[g]),
      .complete_instr(ci_a[g]),
      .data_addr     (data_addr),
      .data_din      (data_din),
      .data_rd       (data_rd),
      .d_macc        (d_macc),
      .data_dout     (ddout_a[g]),
      .complete_data (cd_a[g]),
      .busy          (busy_a[g]),
      .mem_en        (en_a[g]),
      .mem_we        (we_a[g]),
      .mem_addr      (addr_a[g]),
      .mem_wdata     (wdata_a[g]),
      .mem_rdata     (mem_rdata)
    );
  end

  // Synchronous RAM serving whichever instance is active.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_val;
    else if (en_a[active]) begin
      if (we_a[active]) ram[addr_a[active]] <= wdata_a[active];
      else mem_rdata <= ram[addr_a[active]];
    end
  end

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a transaction accepted in an idle cycle t owns cycles t+1..t+WS+3; the RAM strobe
  // lands at t+WS+1 and the completion pulse at t+WS+3.
  logic [15:0] mm [65536];
  int          k = 0;
  logic        m_data = 1'b0, m_wr = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_idout = '0, m_ddout = '0;

  always @(negedge clk) begin
    int  ws;
    bit  dp, ireq;
    logic exp_en;
    ws     = int'(WS_T[active]);
    dp     = DP_T[active];
    ireq   = i_macc && instrmem_rd;
    exp_en = (k == ws + 1) && !rst && (k != 0);
    ci_seen = ci_a[active];
    cd_seen = cd_a[active];
    chk1("mem_en", en_a[active], exp_en);
    chk1("mem_we", we_a[active], exp_en && m_wr);
    if (!rst) begin
      chk1("busy", busy_a[active], k != 0);
      chk16("mem_addr", addr_a[active], m_addr);
      chk16("mem_wdata", wdata_a[active], m_wdata);
      chk1("complete_instr", ci_a[active], (k == ws + 3) && !m_data);
      chk1("complete_data", cd_a[active], (k == ws + 3) && m_data);
      chk16("instr_dout", idout_a[active], m_idout);
      chk16("data_dout", ddout_a[active], m_ddout);
    end
    if (poke_en) mm[poke_addr] = poke_val;
    if (rst) begin
      k = 0; m_addr = '0; m_wdata = '0; m_idout = '0; m_ddout = '0;
    end else if (k == 0) begin
      if (ireq || d_macc) begin
        m_data = d_macc && (dp || !ireq);
        m_wr   = m_data && !data_rd;
        m_addr = m_data ? data_addr : pc;
        if (m_data) m_wdata = data_din;
        k = 1;
      end
    end else begin
      if (k == ws + 1 && m_wr) mm[m_addr] = m_wdata;
      if (k == ws + 2) begin
        if (!m_data) m_idout = mm[m_addr];
        else if (!m_wr) m_ddout = mm[m_addr];
      end
      k = (k == ws + 3) ? 0 : k + 1;
    end
  end

  // Advance one cycle, acting as the core: drop a request the cycle after its completion.
  task automatic step();
    @(posedge clk);
    #1;
    if (cd_seen) d_macc = 1'b0;
    if (ci_seen) i_macc = 1'b0;
  endtask

  task automatic begin_reset(int inst);
    active = inst;
    rst = 1'b1;
    i_macc = 1'b0; instrmem_rd = 1'b0; d_macc = 1'b0; data_rd = 1'b0;
    step();
  endtask

  task automatic poke(logic [15:0] a, logic [15:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    step();
    poke_en = 1'b0;
  endtask

  task automatic end_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: single fetch, no wait states.
    begin_reset(0);
    poke(16'h3000, 16'h1234);
    end_reset();
    pc = 16'h3000; i_macc = 1'b1; instrmem_rd = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk1("t1_mem_en", en_a[0], 1'b1);
        chk16("t1_mem_addr", addr_a[0], 16'h3000);
      end
      chk1("t1_complete_instr", ci_a[0], c == 3);
      if (c == 3) chk16("t1_instr_dout", idout_a[0], 16'h1234);
      step();
    end

    // Test 2: write with two wait states, then read back.
    begin_reset(1);
    end_reset();
    d_macc = 1'b1; data_rd = 1'b0; data_addr = 16'h4000; data_din = 16'hBEEF;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 7) chk1("t2_mem_we", we_a[1], c == 3);
      chk1("t2_complete_data", cd_a[1], c == 5 || c == 12);
      if (c == 5) chk16("t2_dout_after_write", ddout_a[1], 16'h0000);
      if (c == 12) chk16("t2_readback", ddout_a[1], 16'hBEEF);
      step();
      if (c == 6) begin d_macc = 1'b1; data_rd = 1'b1; end
    end

    // Tests 3/4: simultaneous requests under each priority.
    for (int t = 0; t < 2; t++) begin
      int inst;
      inst = (t == 0) ? 0 : 3;
      begin_reset(inst);
      poke(16'h3001, 16'h5678);
      poke(16'h5000, 16'hABCD);
      end_reset();
      pc = 16'h3001; i_macc = 1'b1; instrmem_rd = 1'b1;
      data_addr = 16'h5000; data_rd = 1'b1; d_macc = 1'b1;
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        chk1("t34_complete_data", cd_a[inst], c == ((t == 0) ? 3 : 7));
        chk1("t34_complete_instr", ci_a[inst], c == ((t == 0) ? 7 : 3));
        if (c == 8) begin
          chk16("t34_instr_dout", idout_a[inst], 16'h5678);
          chk16("t34_data_dout", ddout_a[inst], 16'hABCD);
        end
        step();
      end
    end

    // Test 5: fetch request without instrmem_rd is ignored.
    begin_reset(0);
    end_reset();
    i_macc = 1'b1; instrmem_rd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk1("t5_busy", busy_a[0], 1'b0);
      chk1("t5_mem_en", en_a[0], 1'b0);
      chk1("t5_complete_instr", ci_a[0], 1'b0);
      step();
    end

    // Test 6: reset lands on the ISSUE cycle of a write; held request is then served anew.
    begin_reset(2);
    poke(16'h6000, 16'h1111);
    end_reset();
    d_macc = 1'b1; data_rd = 1'b0; data_addr = 16'h6000; data_din = 16'h2222;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk1("t6_mem_en_gated", en_a[2], 1'b0);
        chk1("t6_mem_we_gated", we_a[2], 1'b0);
      end
      if (c == 5) begin
        chk1("t6_busy_cleared", busy_a[2], 1'b0);
        chk16("t6_mem_addr_cleared", addr_a[2], 16'h0000);
        chk16("t6_mem_wdata_cleared", wdata_a[2], 16'h0000);
        chk16("t6_ram_unchanged", ram[16'h6000], 16'h1111);
      end
      chk1("t6_complete_data", cd_a[2], c == 11);
      if (c == 12) chk16("t6_ram_written", ram[16'h6000], 16'h2222);
      step();
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
    end

    // Top-of-memory fetch.
    begin_reset(3);
    poke(16'hFFFF, 16'h0F0F);
    end_reset();
    pc = 16'hFFFF; i_macc = 1'b1; instrmem_rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) chk16("t7_mem_addr", addr_a[3], 16'hFFFF);
      chk1("t7_complete_instr", ci_a[3], c == 3);
      if (c == 3) chk16("t7_instr_dout", idout_a[3], 16'h0F0F);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
